// File: rtl/axis_pkg.sv
// Shared AXI-Stream definitions for the S2MM re-framing path.
package axis_pkg;

  typedef enum logic [1:0] {
    ST_PASS = 2'd0,
    ST_PAD  = 2'd1
  } state_t;

  // Per-lane keep value; replicate across the byte lanes of the stream.
  localparam logic AXIS_KEEP_ALL = 1'b1;

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is visible as soon as it is written.
module sync_fifo_fwft #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_wr;
  logic             do_rd;

  // The extra pointer bit separates "wrapped once" (full) from "equal" (empty).
  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                 (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);

  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  // Gate the head so the data/last outputs read zero while nothing is queued.
  assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/axis_frame_packer.sv
// Re-frames an AXI-Stream into fixed-length DMA frames: drops partial-keep beats,
// forces tlast every FRAME_BEATS beats and pads frames that end early.
module axis_frame_packer
  import axis_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                FIFO_DEPTH  = 16,
  parameter int                FRAME_BEATS = 1024,
  parameter logic [DATA_W-1:0] PAD_WORD    = '0
) (
  input  logic                s_axis_aclk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tvalid,
  output logic                s_axis_tready,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tlast,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic [15:0]         frames_out,
  output logic [15:0]         short_frames,
  output logic [15:0]         drop_cnt,
  output logic [1:0]          state_reg
);

  localparam int                KEEP_W   = DATA_W / 8;
  localparam int                CNT_W    = $clog2(FRAME_BEATS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_BEATS - 1);
  localparam logic [KEEP_W-1:0] KEEP_ALL = {KEEP_W{AXIS_KEEP_ALL}};

  state_t            fsm_state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [15:0]       frames_out_reg;
  logic [15:0]       short_frames_reg;
  logic [15:0]       drop_cnt_reg;

  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_wr_en;
  logic [DATA_W:0]   fifo_wr_data;
  logic [DATA_W:0]   fifo_rd_data;

  logic              s_accept;
  logic              keep_ok;
  logic              beat_last;
  logic              m_handshake;

  assign s_axis_tready = !fifo_full && (fsm_state_reg == ST_PASS);
  assign s_accept      = s_axis_tvalid && s_axis_tready;
  assign keep_ok       = (s_axis_tkeep == KEEP_ALL);
  assign beat_last     = (cnt_reg == CNT_LAST);

  always_comb begin
    fifo_wr_en   = 1'b0;
    fifo_wr_data = {beat_last, s_axis_tdata};
    case (fsm_state_reg)
      ST_PASS: fifo_wr_en = s_accept && keep_ok;
      ST_PAD: begin
        fifo_wr_en   = !fifo_full;
        fifo_wr_data = {beat_last, PAD_WORD};
      end
      default: fifo_wr_en = 1'b0;
    endcase
  end

  sync_fifo_fwft #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (s_axis_aclk),
    .srst    (reset),
    .wr_en   (fifo_wr_en),
    .wr_data (fifo_wr_data),
    .rd_en   (m_axis_tready),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign m_axis_tdata  = fifo_rd_data[DATA_W-1:0];
  assign m_axis_tlast  = fifo_rd_data[DATA_W];
  assign m_axis_tkeep  = KEEP_ALL;
  assign m_handshake   = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge s_axis_aclk) begin
    if (reset) begin
      fsm_state_reg    <= ST_PASS;
      cnt_reg          <= '0;
      frames_out_reg   <= '0;
      short_frames_reg <= '0;
      drop_cnt_reg     <= '0;
    end else begin
      if (m_handshake && m_axis_tlast) frames_out_reg <= frames_out_reg + 16'd1;
      if (fifo_wr_en) cnt_reg <= beat_last ? '0 : cnt_reg + CNT_W'(1);

      case (fsm_state_reg)
        ST_PASS: begin
          if (s_accept && !keep_ok) drop_cnt_reg <= drop_cnt_reg + 16'd1;
          // A tlast landing on the last slot is a normal frame end, not a short frame.
          if (fifo_wr_en && s_axis_tlast && !beat_last) fsm_state_reg <= ST_PAD;
        end
        ST_PAD: begin
          if (fifo_wr_en && beat_last) begin
            fsm_state_reg    <= ST_PASS;
            short_frames_reg <= short_frames_reg + 16'd1;
          end
        end
        default: fsm_state_reg <= ST_PASS;
      endcase
    end
  end

  assign frames_out   = frames_out_reg;
  assign short_frames = short_frames_reg;
  assign drop_cnt     = drop_cnt_reg;
  assign state_reg    = fsm_state_reg;

endmodule
